// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle IEEE-754-style floating-point adder/subtractor
//
// Purpose: adds or subtracts two {sign, exp, frac} operands through a six-state
// FSM (IDLE, ALIGN, ADD, NORM, ROUND, DONE). Rounding is round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero. NaN and Inf operands
// are resolved in ALIGN and then take the same path length as ordinary operands.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; discards any in-flight operation
//   in_valid   operands and op presented
//   in_ready   high only in IDLE
//   op         0: x+y, 1: x-y
//   x, y       operands, W = 1+EXP_W+MAN_W bits
//   out_valid  result and flags valid (DONE)
//   out_ready  consumer accepts the result
//   result     sum or difference
//   flags      {nv, of, uf, nx}
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   x,
  input  logic [EXP_W+MAN_W:0]   y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  // Working significand: {carry, hidden, frac, G, R, S}
  localparam int F   = MAN_W + 5;
  // Signed exponent width, enough headroom for +1 and for -lzc
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(F);
  localparam logic [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;

  // Values carried between stages
  logic          a_sign_q;
  logic          b_sign_q;
  logic [EW-1:0] exp_q;
  logic [F-1:0]  ma_q;
  logic [F-1:0]  mb_q;
  logic          spec_q;
  logic [W-1:0]  spec_res_q;
  logic [3:0]    spec_flags_q;
  logic [F-1:0]  sum_q;
  logic          sign_q;
  logic [F-2:0]  norm_q;
  logic          zero_q;

  assign in_ready = (state == S_IDLE);

  // ---------------------------------------------------------------- ALIGN
  logic             xs, ys;
  logic [EXP_W-1:0] xe, ye;
  logic [MAN_W-1:0] xf, yf;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic [W-2:0]     x_mag, y_mag;
  logic             swap;
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  logic             a_z, b_z;
  logic [F-1:0]     a_sig, b_sig, b_sh, b_al;
  logic [EXP_W-1:0] d;
  logic             lost;
  logic             sp_nan, sp_inf;
  logic [W-1:0]     sp_res;

  always_comb begin
    xs = x_q[W-1];
    xe = x_q[W-2:MAN_W];
    xf = x_q[MAN_W-1:0];
    ys = y_q[W-1];
    ye = y_q[W-2:MAN_W];
    yf = y_q[MAN_W-1:0];

    // A zero exponent field (zero or subnormal) is treated as signed zero
    x_zero = (xe == '0);
    y_zero = (ye == '0);
    x_inf  = (xe == '1) && (xf == '0);
    y_inf  = (ye == '1) && (yf == '0);
    x_nan  = (xe == '1) && (xf != '0);
    y_nan  = (ye == '1) && (yf != '0);

    x_mag = x_zero ? '0 : x_q[W-2:0];
    y_mag = y_zero ? '0 : y_q[W-2:0];
    swap  = (y_mag > x_mag);

    a_s = swap ? ys : xs;
    b_s = swap ? xs : ys;
    a_e = swap ? ye : xe;
    b_e = swap ? xe : ye;
    a_f = swap ? yf : xf;
    b_f = swap ? xf : yf;
    a_z = swap ? y_zero : x_zero;
    b_z = swap ? x_zero : y_zero;

    a_sig = a_z ? '0 : {2'b01, a_f, 3'b000};
    b_sig = b_z ? '0 : {2'b01, b_f, 3'b000};

    d    = a_e - b_e;
    b_sh = '0;
    lost = 1'b0;
    if (32'(d) > 32'(MAN_W + 3)) begin
      // Every significant bit of b falls below S
      b_al = {{(F-1){1'b0}}, |b_sig};
    end else begin
      b_sh = b_sig >> d;
      lost = |(b_sig & ~({F{1'b1}} << d));
      b_al = {b_sh[F-1:1], b_sh[0] | lost};
    end

    // y's sign already carries op, so Inf - Inf shows up as opposite signs here
    sp_nan = x_nan | y_nan | (x_inf & y_inf & (xs != ys));
    sp_inf = x_inf | y_inf;
    if (sp_nan)
      sp_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else
      sp_res = {(x_inf ? xs : ys), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // ---------------------------------------------------------------- ADD
  logic [F-1:0] sum_c;

  always_comb begin
    if (a_sign_q ^ b_sign_q)
      sum_c = ma_q - mb_q;
    else
      sum_c = ma_q + mb_q;
  end

  // ---------------------------------------------------------------- NORM
  logic [LZW-1:0] lz;
  logic           lz_found;
  logic [F-2:0]   norm_c;
  logic [EW-1:0]  nexp_c;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = F - 2; i >= 0; i--) begin
      if (!lz_found) begin
        if (sum_q[i])
          lz_found = 1'b1;
        else
          lz = lz + LZW'(1);
      end
    end

    if (sum_q[F-1]) begin
      // Carry out: shift right one, folding the dropped bit into sticky
      norm_c = {sum_q[F-1:2], sum_q[1] | sum_q[0]};
      nexp_c = exp_q + EW'(1);
    end else begin
      norm_c = sum_q[F-2:0] << lz;
      nexp_c = exp_q - EW'(lz);
    end
  end

  // ---------------------------------------------------------------- ROUND
  logic             rg, rr, rs, rl, rup, rnx;
  logic [MAN_W+1:0] mant;
  logic [EW-1:0]    rexp;
  logic [MAN_W-1:0] rfrac;
  logic             r_of, r_uf;
  logic [W-1:0]     res_c;
  logic [3:0]       flags_c;

  always_comb begin
    rl  = norm_q[3];
    rg  = norm_q[2];
    rr  = norm_q[1];
    rs  = norm_q[0];
    rnx = rg | rr | rs;
    rup = rg & (rr | rs | rl);

    mant  = {1'b0, norm_q[F-2:3]} + {{(MAN_W+1){1'b0}}, rup};
    // Rounding carry (1.11..1 + ulp) becomes 10.00..0: re-normalise
    rexp  = exp_q + {{(EW-1){1'b0}}, mant[MAN_W+1]};
    rfrac = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

    r_of = !rexp[EW-1] && (rexp >= EXP_INF);
    r_uf = rexp[EW-1] || (rexp == '0);

    if (spec_q) begin
      res_c   = spec_res_q;
      flags_c = spec_flags_q;
    end else if (zero_q) begin
      res_c   = {sign_q, {(W-1){1'b0}}};
      flags_c = 4'b0000;
    end else if (r_of) begin
      res_c   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = 4'b0101;
    end else if (r_uf) begin
      res_c   = {sign_q, {(W-1){1'b0}}};
      flags_c = 4'b0011;
    end else begin
      res_c   = {sign_q, rexp[EXP_W-1:0], rfrac};
      flags_c = {3'b000, rnx};
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      a_sign_q     <= 1'b0;
      b_sign_q     <= 1'b0;
      exp_q        <= '0;
      ma_q         <= '0;
      mb_q         <= '0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      sum_q        <= '0;
      sign_q       <= 1'b0;
      norm_q       <= '0;
      zero_q       <= 1'b0;
      result       <= '0;
      flags        <= '0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q   <= x;
            y_q   <= {y[W-1] ^ op, y[W-2:0]};
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          a_sign_q     <= a_s;
          b_sign_q     <= b_s;
          exp_q        <= {2'b00, a_e};
          ma_q         <= a_sig;
          mb_q         <= b_al;
          spec_q       <= sp_nan | sp_inf;
          spec_res_q   <= sp_res;
          spec_flags_q <= {sp_nan, 3'b000};
          state        <= S_ADD;
        end
        S_ADD: begin
          sum_q  <= sum_c;
          // An exact zero is +0 unless both addends were negative
          sign_q <= (sum_c == '0) ? (a_sign_q & b_sign_q) : a_sign_q;
          state  <= S_NORM;
        end
        S_NORM: begin
          norm_q <= norm_c;
          exp_q  <= nexp_c;
          zero_q <= (sum_q == '0);
          state  <= S_ROUND;
        end
        S_ROUND: begin
          result    <= res_c;
          flags     <= flags_c;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - directed self-checking bench for fp_addsub_seq
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, count edges to out_valid, check, then drain.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [31:0] er, input logic [3:0] ef);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    x  = a;
    y  = b;
    op = o;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, 32'(n), 32'd5);
    chk({tag, ".result"}, result, er);
    chk({tag, ".flags"}, 32'(flags), 32'(ef));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".drained_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".drained_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic quiet;
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", result, 32'h0);
    chk("reset.flags", 32'(flags), 32'd0);
    reset = 1'b0;

    run_op("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    run_op("sub_1_1",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_op("sub_3_1",     32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    run_op("cancel",      32'h1FFFFFFF, 32'h9FFFFFF0, 1'b0, 32'h15F00000, 4'b0000);
    run_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_op("tie_odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    run_op("inf_m_inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run_op("nan_in",      32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("inf_pass",    32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_op("underflow",   32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
    run_op("neg0_neg0",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_op("pos0_neg0",   32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    run_op("subnorm_fl",  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);

    // Back-pressure: result must hold while out_ready is low, extra in_valid ignored
    @(negedge clk);
    in_valid = 1'b1;
    x  = 32'h3F800000;
    y  = 32'h40000000;
    op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    x = 32'h40000000;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("bp.latency", 32'(n), 32'd5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_result", result, 32'h40400000);
      chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready), 32'd1);

    // Reset while the operation sits in NORM
    @(negedge clk);
    in_valid = 1'b1;
    x  = 32'h3F800000;
    y  = 32'h3F800000;
    op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_norm.out_valid", 32'(out_valid), 32'd0);
    chk("rst_norm.in_ready", 32'(in_ready), 32'd1);
    chk("rst_norm.result", result, 32'h0);
    quiet = 1'b1;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    chk("rst_norm.nothing_emitted", 32'(quiet), 32'd1);

    run_op("after_reset", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
